// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing defaults and register-index constants for the register file
// scoreboard and anything that addresses it.
package regfile_scoreboard_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 4;
    localparam int DEF_NREGS = 1 << DEF_AW;

    typedef logic [DEF_AW-1:0] reg_idx_t;

    localparam reg_idx_t R0  = 4'd0;
    localparam reg_idx_t R1  = 4'd1;
    localparam reg_idx_t R2  = 4'd2;
    localparam reg_idx_t R3  = 4'd3;
    localparam reg_idx_t R4  = 4'd4;
    localparam reg_idx_t R5  = 4'd5;
    localparam reg_idx_t R6  = 4'd6;
    localparam reg_idx_t R7  = 4'd7;
    localparam reg_idx_t R8  = 4'd8;
    localparam reg_idx_t R9  = 4'd9;
    localparam reg_idx_t R10 = 4'd10;
    localparam reg_idx_t R11 = 4'd11;
    localparam reg_idx_t R12 = 4'd12;
    localparam reg_idx_t R13 = 4'd13;
    localparam reg_idx_t R14 = 4'd14;
    localparam reg_idx_t R15 = 4'd15;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Busy scoreboard: per-register busy bits, sticky double-issue error and the
// stall request. REGFILE_BYPASS_EN lets a same-cycle writeback mask busy.
module regfile_scoreboard_bits
    import regfile_scoreboard_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int NREGS = DEF_NREGS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_dst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             use1,
    input  logic             use2,
    output logic [NREGS-1:0] busy,
    output logic             busy_err,
    output logic             stall
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] clr_mask, set_mask;
    logic             err_q, err_d;
    logic             eff1, eff2;

    // Clear then set, so a re-issued load to the writeback target stays busy.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (we)      clr_mask[wa]       = 1'b1;
        if (mark_en) set_mask[mark_dst] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
        err_d  = err_q | (mark_en & busy_q[mark_dst] & ~(we && (wa == mark_dst)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign eff1 = busy_q[ra1] & ~(we && (wa == ra1));
    assign eff2 = busy_q[ra2] & ~(we && (wa == ra2));
`else
    assign eff1 = busy_q[ra1];
    assign eff2 = busy_q[ra2];
`endif

    assign stall    = (use1 & eff1) | (use2 & eff2);
    assign busy     = busy_q;
    assign busy_err = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Sixteen-entry register file, two combinational read ports and one write
// port, with busy scoreboard. REGFILE_BYPASS_EN enables write-through reads.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW,
    parameter int NREGS = DEF_NREGS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             use1,
    input  logic             use2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_dst,
    output logic             stall,
    output logic [NREGS-1:0] busy,
    output logic             busy_err
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd1 = (we && (wa == ra1)) ? wd : mem_q[ra1];
    assign rd2 = (we && (wa == ra2)) ? wd : mem_q[ra2];
`else
    assign rd1 = mem_q[ra1];
    assign rd2 = mem_q[ra2];
`endif

    regfile_scoreboard_bits #(
        .AW    (AW),
        .NREGS (NREGS)
    ) u_bits (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .wa       (wa),
        .mark_en  (mark_en),
        .mark_dst (mark_dst),
        .ra1      (ra1),
        .ra2      (ra2),
        .use1     (use1),
        .use2     (use2),
        .busy     (busy),
        .busy_err (busy_err),
        .stall    (stall)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Sixteen-entry general-purpose register file with per-register busy scoreboard. Feeds the ALU operand-select muxes (immediate vs. register) and the writeback-select mux.
- Two combinational read ports, one synchronous write port.
- Busy bits track loads issued but not yet written back; the block raises a stall request when a consumer reads a busy register.

Parameters:
WIDTH, 16, data width of each register
NREGS, 16, number of registers
AW, 4, register address width (NREGS = 2**AW)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
ra1  input  AW  read address, port 1 (ALU src A)
ra2  input  AW  read address, port 2 (ALU src B / store data)
use1  input  1  port 1 operand actually consumed this cycle
use2  input  1  port 2 operand actually consumed this cycle
rd1  output  WIDTH  read data, port 1
rd2  output  WIDTH  read data, port 2
we  input  1  write enable (output of writeback-select mux path)
wa  input  AW  write address
wd  input  WIDTH  write data
mark_en  input  1  issue of a load: set busy for mark_dst
mark_dst  input  AW  destination register of issued load
stall  output  1  consumer must hold; operand not yet valid
busy  output  NREGS  current busy vector (debug/observability)
busy_err  output  1  sticky: mark_en hit an already-busy register

Behaviour:
- Reset (async, reset_n=0): all registers 0, busy=0, busy_err=0. Consequently rd1=rd2=0 and stall=0 while in reset.
- Write: on posedge clk with we=1, reg[wa]<=wd. All registers are writable (r0 not hardwired).
- Read: rd1=reg[ra1], rd2=reg[ra2], combinational, zero latency.
- Scoreboard update, per posedge:
  - we=1 clears busy[wa].
  - mark_en=1 sets busy[mark_dst].
  - Same register in same cycle: set wins (clear applied first, then set). A back-to-back load to the same destination stays busy.
- busy_err is set on posedge when mark_en=1 and busy[mark_dst]=1 before the update, unless we=1 && wa==mark_dst that same cycle. It stays set until reset.
- stall = (use1 & busy_eff[ra1]) | (use2 & busy_eff[ra2]). Purely combinational, no registered delay.
  - busy_eff is defined under Optional Feature.
  - use=0 never stalls, even when the register is busy.
- Simultaneous we and mark_en to different registers: both take effect.
- ra1==ra2: both ports return the same value; stall evaluated once per port, result ORed.
- Reset asserted mid-operation clears pending busy bits. Any outstanding load writeback after reset is written normally; the write to an idle register is legal.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through. If we=1 and wa==raN, rdN=wd in the same cycle. busy_eff[raN]=0 in that case (the writeback resolves the hazard this cycle, so no stall).
- Undefined: rdN returns the stored value (old data until the edge); busy_eff=busy, so the consumer stalls one extra cycle after writeback.
- Bench runs both builds.

Decomposition:
- Shared package holds WIDTH/AW/NREGS defaults and a register-index constant set (R0..R15), used by decoder and bench.
- One natural sub-module, regfile_scoreboard_bits. It holds the busy vector, the set/clear priority, busy_err, and busy_eff generation.
- Storage array and read/bypass muxing live in the top module.

Test Plan:
- Reset then read all 16 addresses -> rd1=rd2=0x0000, stall=0, busy=0x0000, busy_err=0.
- Write 0xBEEF to r5, next cycle ra1=5 -> rd1=0xBEEF; with bypass, ra1=5 during the write cycle -> rd1=0xBEEF same cycle, without bypass -> old 0x0000.
- mark_en r3, then ra2=3 use2=1 -> stall=1; use2=0 -> stall=0; we r3=0x1234 -> with bypass stall drops in the write cycle, without bypass one cycle later; busy[3] clears after edge.
- Same cycle we wa=7 and mark_en mark_dst=7 with busy[7]=1 -> busy[7]=1 after edge, busy_err stays 0; mark_en r7 again with no write -> busy_err=1 and remains set.
- mark r2 and r9, assert reset_n=0 mid-stream -> busy=0, regs=0, busy_err=0 immediately (async); after release, write r9=0x00FF -> accepted, stall=0.
- Randomized we/mark/use over 10k cycles vs. reference model -> rd1/rd2/stall/busy match every cycle.
